// File: rtl/alaw_compressor.sv
// 24-bit two's-complement sample to 15-bit signed A-law style code compressor.
// Iterative normaliser: one right-shift per cycle until the magnitude fits the mantissa range.
module alaw_compressor (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] out_code,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, OUT} state_t;

  state_t      state_q;
  logic [23:0] mag_q;
  logic [4:0]  k_q;
  logic        neg_q;
  logic [14:0] code_q;
  logic        valid_q;

  logic [23:0] absSample_d;
  logic [6:0]  mant_d;
  logic [6:0]  kField_d;
  logic [14:0] posCode_d;
  logic [14:0] code_d;

  // Candidate code for the current magnitude; only latched when the FSM decides it fits.
  // In CHECK the mantissa tracks the linear segment (step 2, offset 18); in SHIFT the exponent segments (offset 17).
  always_comb begin
    absSample_d = in_sample[23] ? (~in_sample + 24'd1) : in_sample;
    mant_d      = 7'd0;
    kField_d    = {2'b00, k_q};
    if (state_q == CHECK) begin
      kField_d = 7'd0;
      if (mag_q >= 24'd18) begin
        mant_d = 7'((mag_q[8:0] - 9'd18) >> 1);
      end
    end else begin
      mant_d = 7'(mag_q[7:0] - 8'd17);
    end
    posCode_d = {1'b0, mant_d, kField_d};
    code_d    = neg_q ? (~posCode_d + 15'd1) : posCode_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= 24'd0;
      k_q     <= 5'd0;
      neg_q   <= 1'b0;
      code_q  <= 15'h0000;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q   <= absSample_d;
            neg_q   <= in_sample[23];
            k_q     <= 5'd0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (mag_q <= 24'd272) begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            mag_q   <= mag_q >> 1;
            k_q     <= 5'd1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (mag_q <= 24'd144) begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            mag_q <= mag_q >> 1;
            k_q   <= k_q + 5'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_code  = code_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alaw_compressor.sv
// Directed and randomised checks of alaw_compressor against a scoreboard of expected codes and latencies.
module tb_alaw_compressor;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] out_code;
  logic        out_valid;
  logic        out_ready;

  int testsRun    = 0;
  int testsFailed = 0;
  int measLat;
  logic [14:0] expCodeQ[$];
  int          expLatQ[$];

  alaw_compressor dut (
    .clk       (clk),
    .reset     (reset),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Independent reference: linear segment up to 272, otherwise smallest k with |x|>>k <= 144.
  function automatic logic [14:0] refCode(input logic [23:0] s, output int k);
    logic [23:0] a;
    int          m;
    logic [14:0] p;
    a = s[23] ? (~s + 24'd1) : s;
    if (a <= 24'd272) begin
      k = 0;
      m = (a < 24'd18) ? 0 : int'((a - 24'd18) >> 1);
    end else begin
      k = 1;
      while ((a >> k) > 24'd144) k++;
      m = int'(a >> k) - 17;
    end
    p = {1'b0, 7'(m), 7'(k)};
    return s[23] ? (~p + 15'd1) : p;
  endfunction

  // Queue the expectation, hand the sample over, then wait (bounded) for out_valid.
  task automatic applyStimulus(input logic [23:0] sample, input logic [14:0] expCode, input int expLat);
    int guard;
    expCodeQ.push_back(expCode);
    expLatQ.push_back(expLat);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_sample = sample;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_sample = 24'($urandom);
    measLat = 1;
    while (!out_valid && measLat < 40) begin
      @(posedge clk); #1;
      measLat++;
    end
  endtask

  // Pop and compare the pending result, then complete the handshake with out_ready high.
  task automatic checkOutput(input string tag);
    logic [14:0] expCode;
    int          expLat;
    expCode = expCodeQ.pop_front();
    expLat  = expLatQ.pop_front();
    check({tag, " code"}, 32'(out_code), 32'(expCode));
    check({tag, " latency"}, 32'(measLat), 32'(expLat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " idle after handshake"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    logic [14:0] heldCode;
    logic [14:0] rc;
    logic [23:0] rs;
    int          unstable;
    int          rk;

    reset     = 1'b1;
    in_sample = 24'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_code", 32'(out_code), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);

    // Reset and in_valid together must not start a conversion.
    in_sample = 24'd100;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset with in_valid", {30'd0, in_ready, out_valid}, 32'h2);

    applyStimulus(24'd100, 15'h1480, 2);                   checkOutput("+100");
    applyStimulus(24'd1000, 15'h3603, 5);                  checkOutput("+1000");
    applyStimulus(-24'sd1000, 15'h49FD, 5);                checkOutput("-1000");
    applyStimulus(24'h800000, 15'h4870, 18);               checkOutput("-8388608");
    applyStimulus(24'h7FFFFF, 15'h3710, 18);               checkOutput("+8388607");
    applyStimulus(24'd0, 15'h0000, 2);                     checkOutput("zero");
    applyStimulus(24'd19, 15'h0000, 2);                    checkOutput("+19");
    applyStimulus(-24'sd10, 15'h0000, 2);                  checkOutput("-10");
    applyStimulus(24'd272, 15'h3F80, 2);                   checkOutput("+272");
    applyStimulus(24'd273, 15'h3B81, 3);                   checkOutput("+273");

    // Backpressure: code must hold and new in_valid traffic must be ignored.
    out_ready = 1'b0;
    applyStimulus(24'd1000, 15'h3603, 5);
    heldCode = out_code;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid  = (i % 2 == 0);
      in_sample = 24'($urandom);
      @(posedge clk); #1;
      if (out_code !== heldCode || in_ready !== 1'b0 || out_valid !== 1'b1) unstable++;
    end
    in_valid = 1'b0;
    check("backpressure stable cycles", 32'(unstable), 32'd0);
    checkOutput("backpressure release");
    repeat (3) @(posedge clk);
    #1;
    check("no extra output after release", {30'd0, in_ready, out_valid}, 32'h2);

    // Reset pulse while the normaliser is shifting.
    in_sample = 24'h7FFFFF;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset mid-shift", {30'd0, in_ready, out_valid}, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    check("no output after abort", 32'(out_valid), 32'h0);
    applyStimulus(24'd100, 15'h1480, 2);                   checkOutput("+100 after reset");

    for (int i = 0; i < 8; i++) begin
      rs = (i < 4) ? 24'($urandom_range(0, 600)) : 24'($urandom);
      if (i % 2 == 1) rs = ~rs + 24'd1;
      rc = refCode(rs, rk);
      applyStimulus(rs, rc, 2 + rk);
      checkOutput($sformatf("random 0x%06h", rs));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
